// File: rtl/sha_mem_responder.sv
// Word-addressed single-port memory serving the SHA-256 core port, plus a host port used while the core is idle.
// Core reads have 1-cycle registered latency; host transactions take >=3 cycles and stall while core_en is high.
module sha_mem_responder #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_en,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_ack,
  output logic        err,
  input  logic        err_clr,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  typedef enum logic [1:0] {H_IDLE, H_ACCESS, H_ACK} hstate_t;

  hstate_t     state, state_nxt;
  logic        h_we;
  logic [15:0] h_addr;
  logic [31:0] h_wdata;
  logic        host_cap, host_do;

  logic [31:0] mem_arr [0:DEPTH-1];
  logic        core_ok, host_ok;
  logic        arr_we;
  logic [AW-1:0] arr_idx;
  logic [31:0] arr_wdata, arr_rdata;
  logic        err_set;

  always_comb begin
    state_nxt = state;
    host_cap  = 1'b0;
    host_do   = 1'b0;
    case (state)
      H_IDLE: begin
        if (host_req && !core_en) begin
          host_cap  = 1'b1;
          state_nxt = H_ACCESS;
        end
      end
      H_ACCESS: begin
        if (!core_en) begin
          host_do   = 1'b1;
          state_nxt = H_ACK;
        end
      end
      H_ACK:   state_nxt = H_IDLE;
      default: state_nxt = H_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= H_IDLE;
      h_we    <= 1'b0;
      h_addr  <= '0;
      h_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (host_cap) begin
        h_we    <= host_we;
        h_addr  <= host_addr;
        h_wdata <= host_wdata;
      end
    end
  end

  // The core and the host never touch the array on the same edge, so one shared port suffices.
  assign core_ok   = {1'b0, mem_addr} < DEPTH_L;
  assign host_ok   = {1'b0, h_addr} < DEPTH_L;
  assign arr_we    = core_en ? (mem_we && core_ok) : (host_do && h_we && host_ok);
  assign arr_idx   = core_en ? mem_addr[AW-1:0] : h_addr[AW-1:0];
  assign arr_wdata = core_en ? mem_write_data : h_wdata;
  assign arr_rdata = mem_arr[arr_idx];
  assign err_set   = (core_en && !core_ok) || (host_do && !host_ok);

  always_ff @(posedge clk) begin
    if (arr_we) mem_arr[arr_idx] <= arr_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read_data <= '0;
      host_rdata    <= '0;
      host_ack      <= 1'b0;
      err           <= 1'b0;
      rd_count      <= '0;
      wr_count      <= '0;
    end else begin
      host_ack <= host_do;
      if (core_en) begin
        mem_read_data <= core_ok ? arr_rdata : '0;
        if (mem_we) begin
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end else begin
          if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        end
      end
      if (host_do && !h_we) host_rdata <= host_ok ? arr_rdata : '0;
      // A fresh error outranks a simultaneous clear.
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sha_mem_responder.sv
// Directed bench for sha_mem_responder: table of core accesses plus hand-written host, error, reset and saturation sequences.
module tb_sha_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic        host_req, host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata, host_rdata;
  logic        host_ack, err, err_clr;
  logic [15:0] rd_count, wr_count;

  int checks   = 0;
  int failures = 0;

  sha_mem_responder #(.DEPTH(1024)) dut (
    .clk(clk), .reset_n(reset_n), .core_en(core_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack), .err(err), .err_clr(err_clr),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [15:0] exp_rc;
    logic [15:0] exp_wc;
    logic        exp_err;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_xfer(input logic we, input logic [15:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int lat);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!host_ack && lat < 20);
    rd = host_rdata;
    if (!host_ack) begin
      checks++;
      failures++;
      $display("FAIL host_ack_timeout: got no ack after %0d cycles, required ack", lat);
    end
    host_req = 1'b0;
    tick();
  endtask

  logic [31:0] pre_dat [6];
  logic [15:0] pre_adr [6];
  logic [31:0] rdv;
  int          lat;
  int          ack_seen;

  initial begin
    reset_n = 1'b0; core_en = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_write_data = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; err_clr = 1'b0;

    //               en    we    addr     wdata          exp_rd         rc      wc     err
    vt[0] = '{1'b1, 1'b0, 16'd0,    32'h0,        32'h11111111, 16'd1, 16'd0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 16'd1,    32'h0,        32'h12121212, 16'd2, 16'd0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 16'd2,    32'h0,        32'h13131313, 16'd3, 16'd0, 1'b0};
    vt[3] = '{1'b1, 1'b0, 16'd3,    32'h0,        32'h14141414, 16'd4, 16'd0, 1'b0};
    vt[4] = '{1'b1, 1'b1, 16'd5,    32'h5555FFFF, 32'hAAAA0000, 16'd4, 16'd1, 1'b0};
    vt[5] = '{1'b1, 1'b0, 16'd5,    32'h0,        32'h5555FFFF, 16'd5, 16'd1, 1'b0};
    vt[6] = '{1'b0, 1'b1, 16'd5,    32'h0,        32'h5555FFFF, 16'd5, 16'd1, 1'b0};
    vt[7] = '{1'b1, 1'b0, 16'd7,    32'h0,        32'hCAFEBABE, 16'd6, 16'd1, 1'b0};
    vt[8] = '{1'b1, 1'b0, 16'd1024, 32'h0,        32'h00000000, 16'd7, 16'd1, 1'b1};
    vt[9] = '{1'b1, 1'b0, 16'd3,    32'h0,        32'h14141414, 16'd8, 16'd1, 1'b1};

    pre_adr[0] = 16'd0; pre_dat[0] = 32'h11111111;
    pre_adr[1] = 16'd1; pre_dat[1] = 32'h12121212;
    pre_adr[2] = 16'd2; pre_dat[2] = 32'h13131313;
    pre_adr[3] = 16'd3; pre_dat[3] = 32'h14141414;
    pre_adr[4] = 16'd5; pre_dat[4] = 32'hAAAA0000;
    pre_adr[5] = 16'd7; pre_dat[5] = 32'hCAFEBABE;

    #12;
    chk("rst_mem_read_data", mem_read_data, 32'h0);
    chk("rst_host_rdata", host_rdata, 32'h0);
    chk("rst_host_ack", {31'd0, host_ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rd_count", {16'd0, rd_count}, 32'd0);
    chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Host preload with the core idle: ack after exactly two edges.
    for (int i = 0; i < 6; i++) begin
      host_xfer(1'b1, pre_adr[i], pre_dat[i], rdv, lat);
      chk("preload_latency", lat, 32'd2);
    end
    chk("preload_counters", {rd_count, wr_count}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      core_en = vt[i].en; mem_we = vt[i].we; mem_addr = vt[i].addr; mem_write_data = vt[i].wdata;
      tick();
      chk($sformatf("vec%0d_rdata", i), mem_read_data, vt[i].exp_rd);
      chk($sformatf("vec%0d_rd_count", i), {16'd0, rd_count}, {16'd0, vt[i].exp_rc});
      chk($sformatf("vec%0d_wr_count", i), {16'd0, wr_count}, {16'd0, vt[i].exp_wc});
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vt[i].exp_err});
    end

    // Clear coinciding with a new out-of-range read: error wins.
    err_clr = 1'b1; core_en = 1'b1; mem_we = 1'b0; mem_addr = 16'd2000;
    tick();
    chk("errclr_collide_err", {31'd0, err}, 32'd1);
    chk("errclr_collide_rdata", mem_read_data, 32'h0);
    core_en = 1'b0;
    tick();
    chk("errclr_alone", {31'd0, err}, 32'd0);
    err_clr = 1'b0;

    // Out-of-range host write must not alias onto address 3.
    host_xfer(1'b1, 16'd1027, 32'hBADBAD00, rdv, lat);
    chk("host_oor_err", {31'd0, err}, 32'd1);
    host_xfer(1'b0, 16'd3, 32'h0, rdv, lat);
    chk("host_rd3_after_oor", rdv, 32'h14141414);
    chk("host_rd_latency", lat, 32'd2);
    chk("host_err_sticky", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", {31'd0, err}, 32'd0);

    // Core priority: host read stays pending while core_en is high.
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'd7;
    tick();
    core_en = 1'b1; mem_we = 1'b0; mem_addr = 16'd0;
    ack_seen = 0;
    repeat (10) begin
      tick();
      if (host_ack) ack_seen++;
    end
    chk("prio_no_ack", ack_seen, 32'd0);
    core_en = 1'b0;
    tick();
    chk("prio_ack", {31'd0, host_ack}, 32'd1);
    chk("prio_rdata", host_rdata, 32'hCAFEBABE);
    chk("prio_core_rdata", mem_read_data, 32'h11111111);
    chk("prio_rd_count", {16'd0, rd_count}, 32'd19);
    host_req = 1'b0;
    tick();
    chk("prio_ack_drop", {31'd0, host_ack}, 32'd0);

    // Reset while a host write is in H_ACCESS.
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'd5; host_wdata = 32'hDEADBEEF;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_host_ack", {31'd0, host_ack}, 32'd0);
    chk("arst_rd_count", {16'd0, rd_count}, 32'd0);
    chk("arst_wr_count", {16'd0, wr_count}, 32'd0);
    host_req = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    core_en = 1'b1; mem_we = 1'b0; mem_addr = 16'd5;
    tick();
    chk("arst_word_kept", mem_read_data, 32'h5555FFFF);
    chk("arst_rd_count_after", {16'd0, rd_count}, 32'd1);

    // Saturation: 65540 more reads.
    mem_addr = 16'd0;
    repeat (65540) tick();
    chk("sat_rd_count", {16'd0, rd_count}, 32'h0000FFFF);
    chk("sat_wr_count", {16'd0, wr_count}, 32'd0);
    core_en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha_mem_responder.md
# sha_mem_responder

Word-addressed memory responder that serves the SHA-256 core's memory master port (mem_we / mem_addr / mem_write_data / mem_read_data) with registered one-cycle read latency. It also gives a host port for preloading message words and reading back the hash when the core is idle, plus sticky range-error and access-count status. It sits between the SHA-256 core and the testbench or system bus, as the responder end of the core's memory interface.

## Interface
- DEPTH, 1024: number of 32-bit words; legal addresses 0..DEPTH-1 (DEPTH ≤ 65536).
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- core_en  in  1  core owns the array (tie to !done of the core); core port is ignored when low.
- mem_we  in  1  core write enable (1 = write, 0 = read).
- mem_addr  in  16  core word address.
- mem_write_data  in  32  core write data.
- mem_read_data  out  32  core read data, registered.
- host_req  in  1  host request; held high until host_ack.
- host_we  in  1  host write (1) / read (0); sampled with host_req.
- host_addr  in  16  host word address.
- host_wdata  in  32  host write data.
- host_rdata  out  32  host read data; valid while host_ack = 1.
- host_ack  out  1  one-cycle completion pulse.
- err  out  1  sticky out-of-range flag.
- err_clr  in  1  clears err.
- rd_count  out  16  core reads serviced, saturating at 16'hFFFF.
- wr_count  out  16  core writes serviced, saturating at 16'hFFFF.

## Operation
- Reset values: mem_read_data 0, host_rdata 0, host_ack 0, err 0, rd_count 0, wr_count 0, host FSM H_IDLE. Array contents are not reset.
- Core port, active only when core_en = 1, one access every cycle:
  - mem_we = 1: array[mem_addr] <= mem_write_data; wr_count += 1.
  - mem_we = 0: rd_count += 1.
  - Every core cycle is read-first: mem_read_data <= old array[mem_addr], including write cycles.
- core_en = 0: the core port is ignored, mem_read_data holds, and the counters hold.
- Out-of-range access (addr ≥ DEPTH) on either port:
  - Writes are dropped.
  - Reads return 32'h0.
  - err is set.
  - Core counters still increment.
- err precedence: err_clr clears err, but a new error in the same cycle wins, so err = 1.
- Host FSM:
  - H_IDLE to H_ACCESS when host_req = 1 and core_en = 0. host_we, host_addr and host_wdata are latched at that edge.
  - H_ACCESS to H_ACK when core_en = 0. The latched access is performed, host_rdata is loaded (reads only), and host_ack <= 1.
  - H_ACCESS holds while core_en = 1. The core has absolute priority and the host transaction stays pending.
  - H_ACK to H_IDLE unconditionally; host_ack <= 0.
- Host writes leave host_rdata unchanged.
- A host_req still high in H_IDLE after an ack starts a new transaction.
- The core and the host never access the array on the same edge, so the array is single-port.

## Timing
- Core read latency: 1 cycle. mem_addr is sampled at edge N and the data is on mem_read_data after edge N. This matches the core's one-address read lag.
- Core write: committed at the sampling edge. A read of the same address on the next edge returns the new data.
- Host transaction with core_en = 0 throughout:
  - Request captured at edge E0.
  - Array access at E1; host_ack high from E1 to E2.
  - Back in H_IDLE at E2.
  - Minimum 3 cycles per transaction.
- Each cycle core_en = 1 during H_ACCESS adds one cycle of latency. core_en rising while in H_IDLE blocks capture.
- Counters saturate; there is no wrap.
- Asynchronous reset mid-transaction aborts it: host_ack goes to 0 immediately, any pending host write is discarded, and the array keeps its contents.

## Test plan
- Host preload then core readback: host writes 0x11111111..0x14 to addresses 0..3 (core_en = 0), then core reads 0..3 on consecutive cycles → mem_read_data = 0x11111111..0x14, each one cycle after its address; rd_count = 4.
- Read-first collision: array[5] = 0xAAAA0000, core writes 0x5555FFFF to 5 → that cycle's mem_read_data = 0xAAAA0000; next read of 5 → 0x5555FFFF; wr_count = 1.
- Core priority: host read of addr 7 (= 0xCAFEBABE) issued, core_en raised for 10 cycles while in H_ACCESS → no host_ack during those cycles; ack arrives on the edge after core_en falls, with host_rdata = 0xCAFEBABE.
- Range error: core reads DEPTH → mem_read_data = 0, err = 1. Host writes DEPTH+3 → array unchanged. err_clr in the same cycle as a new error → err stays 1; err_clr alone → err = 0.
- Reset mid-host-write (assert reset_n = 0 in H_ACCESS) → host_ack = 0 and counters = 0 asynchronously; target word keeps its previous value.
- Saturation: 65,540 core reads → rd_count = 16'hFFFF.
